strobe_rx: RTL and testbench
============================

STROBE_RX -- requirements
Module: strobe_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the number of payload bits per frame (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: sample strobe; D is examined only on cycles where enable=1.
REQ-005 The block SHALL have port D, input, 1 bit: serial line, idle-high, LSB-first framing.
REQ-006 The block SHALL have port out_data, output, DATA_W bits: last delivered payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds an undelivered payload.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data when out_valid=1 and out_ready=1 in the same cycle.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on bad stop bit.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky; a complete frame was dropped because out_valid was held.

Function
REQ-011 The block SHALL implement three states: IDLE, DATA, STOP.
REQ-012 On cycles with enable=0, the block SHALL hold state, bit counter and shift register unchanged; only the out_valid/out_ready handshake SHALL proceed.
REQ-013 In IDLE with enable=1 and D=0 (start bit), the block SHALL go to DATA with bit counter=0; with D=1 it SHALL stay in IDLE.
REQ-014 In DATA with enable=1, the block SHALL shift D into the MSB of the shift register (right shift, LSB first) and increment the counter; on the strobe where counter=DATA_W-1 it SHALL go to STOP.
REQ-015 In STOP with enable=1 and D=1, the block SHALL deliver the shift register: if out_valid=0 or out_ready=1 in that cycle, load out_data and set out_valid=1 on the next edge; otherwise the frame SHALL be dropped, out_data left unchanged, and overrun set to 1.
REQ-016 In STOP with enable=1 and D=0, the block SHALL discard the frame, assert frame_err for exactly one cycle, and leave out_valid and overrun unchanged.
REQ-017 From STOP, any enable=1 cycle SHALL return the FSM to IDLE; a start bit SHALL NOT be recognised in that same cycle.
REQ-018 out_valid SHALL clear on the edge after a cycle with out_valid=1 and out_ready=1, unless a new load occurs that same cycle, in which case out_valid SHALL stay 1 with new data.
REQ-019 Latency SHALL be one cycle from the clock edge that samples the stop bit to out_valid=1.
REQ-020 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 overrun SHALL remain 1 until reset.

Reset
REQ-022 With reset=1 at a rising edge, the block SHALL set: state=IDLE, counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0.
REQ-023 Reset SHALL take priority over all other inputs; reset mid-frame SHALL abandon the frame with no frame_err pulse.

Structure
REQ-024 The state enumeration (IDLE, DATA, STOP) and the DATA_W default constant SHALL live in a shared package, strobe_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; the counter width SHALL be $clog2(DATA_W).

Verification
REQ-026 The bench SHALL cover this scenario: reset held 2 cycles -> all outputs 0, state IDLE.
REQ-027 The bench SHALL cover this scenario: enable=1 every cycle, send start 0, payload 0xA5 LSB-first, stop 1, out_ready=1 -> out_data=0xA5, out_valid high for exactly 1 cycle, 1 cycle after the stop edge.
REQ-028 The bench SHALL cover this scenario: same frame 0x3C with enable high only every 3rd cycle, D changing between strobes -> out_data=0x3C; intervening D values are ignored.
REQ-029 The bench SHALL cover this scenario: out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, out_valid=1, overrun=1; after out_ready=1 for 1 cycle, out_valid=0.
REQ-030 The bench SHALL cover this scenario: frame 0x7E with stop bit 0 -> frame_err pulses 1 cycle, out_valid stays 0; a following good frame 0x81 is delivered.
REQ-031 The bench SHALL cover this scenario: reset asserted after the 4th data bit of a frame -> outputs 0, no frame_err; the next frame 0x55 is received correctly.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared types and defaults for the strobe-sampled serial receiver.
package strobe_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/strobe_rx.sv
// Serial receiver: idle-high line, start bit, LSB-first payload, stop bit,
// sampled only on enable strobes, with a valid/ready output register.
module strobe_rx
  import strobe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              D,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovr;
  logic               w_free;

  // The output slot can take a new frame if empty or being drained now.
  assign w_free = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_valid && out_ready)
        r_valid <= 1'b0;
      if (enable) begin
        unique case (r_state)
          IDLE: begin
            if (!D) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shift <= {D, r_shift[DATA_W-1:1]};
            if (r_cnt == LAST) begin
              r_state <= STOP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          STOP: begin
            r_state <= IDLE;
            if (D) begin
              if (w_free) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_strobe_rx.sv
// Directed self-checking bench for strobe_rx.
`timescale 1ns/1ps
module tb_strobe_rx;
  import strobe_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       D = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int n_run = 0;
  int n_fail = 0;

  strobe_rx #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .D         (D),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge; they are sampled at the next edge.
  task automatic tick(input logic en, input logic d);
    enable = en;
    D      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_fast(input logic [7:0] v, input logic stop);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, v[i]);
    tick(1'b1, stop);
  endtask

  task automatic send_slow(input logic [7:0] v, input logic stop);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, v[i]);
      tick(1'b0, ~v[i]);
      tick(1'b0, v[i]);
    end
    tick(1'b1, stop);
  endtask

  initial begin
    // reset held two cycles
    reset = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    reset = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("idle_stay", 32'(dut.r_state), 32'(IDLE));

    // 0xA5, enable every cycle, ready high
    out_ready = 1'b1;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'hA5 >> i);
    chk("a5_pre_valid", 32'(out_valid), 32'h0);
    chk("a5_stop_state", 32'(dut.r_state), 32'(STOP));
    tick(1'b1, 1'b1);
    chk("a5_valid", 32'(out_valid), 32'h1);
    chk("a5_data", 32'(out_data), 32'hA5);
    tick(1'b1, 1'b1);
    chk("a5_valid_clr", 32'(out_valid), 32'h0);
    chk("a5_data_hold", 32'(out_data), 32'hA5);

    // 0x3C with a strobe every third cycle
    send_slow(8'h3C, 1'b1);
    chk("3c_valid", 32'(out_valid), 32'h1);
    chk("3c_data", 32'(out_data), 32'h3C);
    tick(1'b0, 1'b0);
    chk("3c_valid_clr", 32'(out_valid), 32'h0);
    chk("3c_state", 32'(dut.r_state), 32'(IDLE));

    // backpressure: 0x11 held, 0x22 dropped
    out_ready = 1'b0;
    send_fast(8'h11, 1'b1);
    chk("ovr_first_valid", 32'(out_valid), 32'h1);
    chk("ovr_first_data", 32'(out_data), 32'h11);
    chk("ovr_first_flag", 32'(overrun), 32'h0);
    send_fast(8'h22, 1'b1);
    chk("ovr_data_stable", 32'(out_data), 32'h11);
    chk("ovr_valid", 32'(out_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    chk("ovr_drain", 32'(out_valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // bad stop bit on 0x7E, then good 0x81
    send_fast(8'h7E, 1'b0);
    chk("fe_pulse", 32'(frame_err), 32'h1);
    chk("fe_valid", 32'(out_valid), 32'h0);
    chk("fe_data", 32'(out_data), 32'h11);
    chk("fe_idle", 32'(dut.r_state), 32'(IDLE));
    tick(1'b0, 1'b1);
    chk("fe_one_cycle", 32'(frame_err), 32'h0);
    chk("fe_ovr_hold", 32'(overrun), 32'h1);
    send_fast(8'h81, 1'b1);
    chk("81_valid", 32'(out_valid), 32'h1);
    chk("81_data", 32'(out_data), 32'h81);
    chk("81_no_ferr", 32'(frame_err), 32'h0);
    tick(1'b1, 1'b1);
    chk("81_clr", 32'(out_valid), 32'h0);

    // reset after the fourth data bit
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h96 >> i);
    chk("mid_state", 32'(dut.r_state), 32'(DATA));
    reset = 1'b1;
    tick(1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_data", 32'(out_data), 32'h0);
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_ovr", 32'(overrun), 32'h0);
    chk("mid_ferr", 32'(frame_err), 32'h0);
    chk("mid_state_idle", 32'(dut.r_state), 32'(IDLE));
    tick(1'b1, 1'b1);
    chk("mid_ferr_after", 32'(frame_err), 32'h0);
    send_fast(8'h55, 1'b1);
    chk("55_valid", 32'(out_valid), 32'h1);
    chk("55_data", 32'(out_data), 32'h55);
    chk("55_ovr", 32'(overrun), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
